// File: rtl/gen_skid_buffer.sv
// gen_skid_buffer: two-entry ready/valid slice with registered storage.
// Define GEN_SKID_BUFFER_BYPASS_EN for a combinational enq->deq path while empty.
module gen_skid_buffer #(
  parameter int DW = 32,
  parameter logic [DW-1:0] rstValue = {DW{1'b0}}
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          flush,
  input  logic          enq_valid,
  output logic          enq_ready,
  input  logic [DW-1:0] enq_data,
  output logic          deq_valid,
  input  logic          deq_ready,
  output logic [DW-1:0] deq_data,
  output logic [1:0]    count
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t state, state_nx;
  logic [DW-1:0] main_q, skid_q;
  logic enq_fire, deq_fire, load_main, load_skid, from_skid;
  assign enq_ready = (state != FULL) & !flush;
`ifdef GEN_SKID_BUFFER_BYPASS_EN
  logic bypass;
  assign bypass    = (state == EMPTY) & !flush;
  assign deq_valid = bypass ? enq_valid : (state != EMPTY) & !flush;
  assign deq_data  = bypass ? enq_data : main_q;
`else
  assign deq_valid = (state != EMPTY) & !flush;
  assign deq_data  = main_q;
`endif
  assign enq_fire = enq_valid & enq_ready;
  assign deq_fire = deq_valid & deq_ready;
  assign count    = state;
  always_comb begin
    state_nx  = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    from_skid = 1'b0;
    if (flush) state_nx = EMPTY;
    else begin
      unique case (state)
        EMPTY: begin
          // an enq consumed in the same cycle (bypass) never lands in storage
          load_main = enq_fire & !deq_fire;
          state_nx  = load_main ? ONE : EMPTY;
        end
        ONE: begin
          load_main = enq_fire & deq_fire;
          load_skid = enq_fire & !deq_fire;
          state_nx  = load_skid ? FULL : (deq_fire & !enq_fire) ? EMPTY : ONE;
        end
        FULL: begin
          load_main = deq_fire;
          from_skid = deq_fire;
          state_nx  = deq_fire ? ONE : FULL;
        end
        default: state_nx = EMPTY;
      endcase
    end
  end
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state  <= EMPTY;
      main_q <= rstValue;
      skid_q <= rstValue;
    end else begin
      state <= state_nx;
      if (load_main) main_q <= from_skid ? skid_q : enq_data;
      if (load_skid) skid_q <= enq_data;
    end
  end
endmodule

// File: tb/tb_gen_skid_buffer.sv
// tb_gen_skid_buffer: directed self-checking bench for gen_skid_buffer.
module tb_gen_skid_buffer;
  localparam logic [31:0] RV = 32'hDEAD_BEEF;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic enq_valid = 1'b0, enq_ready, deq_valid, deq_ready = 1'b0;
  logic [31:0] enq_data = '0, deq_data;
  logic [1:0] count;
  int total = 0, bad = 0;
  gen_skid_buffer #(.DW(32), .rstValue(RV)) dut (
    .CLK(clk), .RSTn(rst_n), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data),
    .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // inputs change at the falling edge; outputs are sampled 1 time unit later
  task automatic drive(input logic ev, input logic [31:0] ed, input logic dr, input logic fl);
    @(negedge clk);
    enq_valid = ev;
    enq_data  = ed;
    deq_ready = dr;
    flush     = fl;
    #1;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_dvalid", deq_valid, 0);
    chk("rst_eready", enq_ready, 1);
    chk("rst_ddata", deq_data, RV);
    for (int i = 1; i <= 8; i++) begin
      drive(1, i, 1, 0);
      chk("str_eready", enq_ready, 1);
      if (i == 1) chk("str_first_dvalid", deq_valid, 0);
      else begin
        chk("str_dvalid", deq_valid, 1);
        chk("str_ddata", deq_data, i - 1);
        chk("str_count", count, 1);
      end
    end
    drive(0, 0, 1, 0);
    chk("str_last_data", deq_data, 8);
    chk("str_last_count", count, 1);
    drive(0, 0, 1, 0);
    chk("str_end_count", count, 0);
    chk("str_end_dvalid", deq_valid, 0);
    drive(1, 32'hA, 0, 0);
    chk("bp_a_eready", enq_ready, 1);
    drive(1, 32'hB, 0, 0);
    chk("bp_b_eready", enq_ready, 1);
    chk("bp_b_ddata", deq_data, 32'hA);
    drive(1, 32'hC, 0, 0);
    chk("bp_full_count", count, 2);
    chk("bp_full_eready", enq_ready, 0);
    chk("bp_hold_ddata", deq_data, 32'hA);
    drive(1, 32'hC, 1, 0);
    chk("bp_out_a", deq_data, 32'hA);
    chk("bp_out_a_eready", enq_ready, 0);
    drive(1, 32'hC, 1, 0);
    chk("bp_out_b", deq_data, 32'hB);
    chk("bp_rec_eready", enq_ready, 1);
    chk("bp_rec_count", count, 1);
    drive(0, 0, 1, 0);
    chk("bp_out_c", deq_data, 32'hC);
    chk("bp_out_c_valid", deq_valid, 1);
    drive(1, 32'h11, 0, 0);
    chk("bp_end_count", count, 0);
    drive(1, 32'h22, 0, 0);
    drive(0, 0, 1, 1);
    chk("fl_count_before", count, 2);
    chk("fl_dvalid", deq_valid, 0);
    chk("fl_eready", enq_ready, 0);
    drive(1, 32'h33, 0, 0);
    chk("fl_after_count", count, 0);
    chk("fl_after_dvalid", deq_valid, 0);
    chk("fl_after_eready", enq_ready, 1);
    drive(0, 0, 1, 0);
    chk("fl_next_data", deq_data, 32'h33);
    chk("fl_next_dvalid", deq_valid, 1);
    drive(1, 32'h44, 0, 0);
    chk("pre_rst_count", count, 0);
    drive(1, 32'h55, 0, 0);
    drive(0, 0, 0, 0);
    chk("pre_rst_full", count, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_dvalid", deq_valid, 0);
    chk("arst_ddata", deq_data, RV);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 32'h5A, 1, 0);
`ifdef GEN_SKID_BUFFER_BYPASS_EN
    chk("byp_dvalid", deq_valid, 1);
    chk("byp_ddata", deq_data, 32'h5A);
    drive(0, 0, 1, 0);
    chk("byp_count", count, 0);
    chk("byp_after_dvalid", deq_valid, 0);
`else
    chk("nbyp_dvalid", deq_valid, 0);
    drive(0, 0, 1, 0);
    chk("nbyp_count", count, 1);
    chk("nbyp_ddata", deq_data, 32'h5A);
    drive(0, 0, 1, 0);
    chk("nbyp_drain", count, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
